// File: rtl/decode_execute_latch_pkg.sv
// Shared encodings for the decode/execute boundary: opcodes, ALU ops,
// fixed destination registers and the bubble instruction word.
package decode_execute_latch_pkg;

  localparam int OPCODE_W = 5;
  localparam int ALU_OP_W = 5;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_J     = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_JR    = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_BLT   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SW    = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_LW    = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_SETX  = 5'b10101;
  localparam logic [OPCODE_W-1:0] OP_BEX   = 5'b10110;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 5'b00001;

  localparam logic [4:0] REG_RA     = 5'd31;
  localparam logic [4:0] REG_STATUS = 5'd30;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  function automatic logic [OPCODE_W-1:0] insn_opcode(input logic [31:0] insn);
    return insn[31:27];
  endfunction

endpackage

// File: rtl/decode_execute_latch_ctrl.sv
// Combinational pre-decode of execute-stage control (ALU op, operand-B
// select, destination register) from the decode-stage instruction fields.
module execute_control_decode
  import decode_execute_latch_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ALU_OP_W-1:0] func,
  input  logic [4:0]          rd_field,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                b_sel,
  output logic [REG_W-1:0]    rd
);

  always_comb begin
    alu_op = ALU_ADD;
    b_sel  = 1'b0;
    rd     = '0;
    case (opcode)
      OP_RTYPE: begin
        alu_op = func;
        rd     = REG_W'(rd_field);
      end
      OP_ADDI, OP_LW: begin
        b_sel = 1'b1;
        rd    = REG_W'(rd_field);
      end
      // Stores use the rd field as a source, so nothing is written back.
      OP_SW: begin
        b_sel = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        alu_op = ALU_SUB;
      end
      OP_JAL:  rd = REG_W'(REG_RA);
      OP_SETX: rd = REG_W'(REG_STATUS);
      default: begin
        alu_op = ALU_ADD;
        b_sel  = 1'b0;
        rd     = '0;
      end
    endcase
  end

endmodule

// File: rtl/decode_execute_latch.sv
// Decode-to-execute pipeline register with stall (hold) and flush (bubble);
// flush outranks stall, reset outranks both.
module decode_execute_latch
  import decode_execute_latch_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          REG_W    = 5,
  parameter logic [31:0] NOP_INSN = decode_execute_latch_pkg::NOP_INSN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [31:0]         insn_in,
  input  logic [DATA_W-1:0]   rs_data_in,
  input  logic [DATA_W-1:0]   rt_data_in,
  input  logic [DATA_W-1:0]   imm_ext_in,
  output logic                valid_out,
  output logic [DATA_W-1:0]   pc_out,
  output logic [31:0]         insn_out,
  output logic [DATA_W-1:0]   rs_data_out,
  output logic [DATA_W-1:0]   rt_data_out,
  output logic [DATA_W-1:0]   imm_out,
  output logic [DATA_W-1:0]   alu_b_out,
  output logic [ALU_OP_W-1:0] alu_op_out,
  output logic [4:0]          shamt_out,
  output logic [REG_W-1:0]    rd_out,
  output logic                b_sel_out
);

  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_b_sel;
  logic [REG_W-1:0]    dec_rd;

  execute_control_decode #(
    .REG_W (REG_W)
  ) u_ctrl (
    .opcode   (insn_opcode(insn_in)),
    .func     (insn_in[6:2]),
    .rd_field (insn_in[26:22]),
    .alu_op   (dec_alu_op),
    .b_sel    (dec_b_sel),
    .rd       (dec_rd)
  );

  logic                valid_reg,  valid_next;
  logic [DATA_W-1:0]   pc_reg,     pc_next;
  logic [31:0]         insn_reg,   insn_next;
  logic [DATA_W-1:0]   rs_reg,     rs_next;
  logic [DATA_W-1:0]   rt_reg,     rt_next;
  logic [DATA_W-1:0]   imm_reg,    imm_next;
  logic [DATA_W-1:0]   alu_b_reg,  alu_b_next;
  logic [ALU_OP_W-1:0] alu_op_reg, alu_op_next;
  logic [4:0]          shamt_reg,  shamt_next;
  logic [REG_W-1:0]    rd_reg,     rd_next;
  logic                b_sel_reg,  b_sel_next;

  logic load_bubble;
  logic load_capture;

  // A capture of an invalid decode slot is indistinguishable from a bubble.
  assign load_bubble  = flush || (!stall && !valid_in);
  assign load_capture = !flush && !stall && valid_in;

  always_comb begin
    valid_next  = valid_reg;
    pc_next     = pc_reg;
    insn_next   = insn_reg;
    rs_next     = rs_reg;
    rt_next     = rt_reg;
    imm_next    = imm_reg;
    alu_b_next  = alu_b_reg;
    alu_op_next = alu_op_reg;
    shamt_next  = shamt_reg;
    rd_next     = rd_reg;
    b_sel_next  = b_sel_reg;
    if (load_bubble) begin
      valid_next  = 1'b0;
      pc_next     = '0;
      insn_next   = NOP_INSN;
      rs_next     = '0;
      rt_next     = '0;
      imm_next    = '0;
      alu_b_next  = '0;
      alu_op_next = '0;
      shamt_next  = '0;
      rd_next     = '0;
      b_sel_next  = 1'b0;
    end else if (load_capture) begin
      valid_next  = 1'b1;
      pc_next     = pc_in;
      insn_next   = insn_in;
      rs_next     = rs_data_in;
      rt_next     = rt_data_in;
      imm_next    = imm_ext_in;
      alu_b_next  = dec_b_sel ? imm_ext_in : rt_data_in;
      alu_op_next = dec_alu_op;
      shamt_next  = insn_in[11:7];
      rd_next     = dec_rd;
      b_sel_next  = dec_b_sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      pc_reg     <= '0;
      insn_reg   <= NOP_INSN;
      rs_reg     <= '0;
      rt_reg     <= '0;
      imm_reg    <= '0;
      alu_b_reg  <= '0;
      alu_op_reg <= '0;
      shamt_reg  <= '0;
      rd_reg     <= '0;
      b_sel_reg  <= 1'b0;
    end else begin
      valid_reg  <= valid_next;
      pc_reg     <= pc_next;
      insn_reg   <= insn_next;
      rs_reg     <= rs_next;
      rt_reg     <= rt_next;
      imm_reg    <= imm_next;
      alu_b_reg  <= alu_b_next;
      alu_op_reg <= alu_op_next;
      shamt_reg  <= shamt_next;
      rd_reg     <= rd_next;
      b_sel_reg  <= b_sel_next;
    end
  end

  assign valid_out   = valid_reg;
  assign pc_out      = pc_reg;
  assign insn_out    = insn_reg;
  assign rs_data_out = rs_reg;
  assign rt_data_out = rt_reg;
  assign imm_out     = imm_reg;
  assign alu_b_out   = alu_b_reg;
  assign alu_op_out  = alu_op_reg;
  assign shamt_out   = shamt_reg;
  assign rd_out      = rd_reg;
  assign b_sel_out   = b_sel_reg;

endmodule

// File: tb/tb_decode_execute_latch.sv
// Directed bench for decode_execute_latch: reset, capture per opcode class,
// stall, flush, destination overrides and reset during stall.
module tb_decode_execute_latch;

  logic        clock = 1'b0;
  logic        reset, stall, flush, valid_in;
  logic [31:0] pc_in, insn_in, rs_data_in, rt_data_in, imm_ext_in;
  logic        valid_out, b_sel_out;
  logic [31:0] pc_out, insn_out, rs_data_out, rt_data_out, imm_out, alu_b_out;
  logic [4:0]  alu_op_out, shamt_out, rd_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  decode_execute_latch dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .valid_in    (valid_in),
    .pc_in       (pc_in),
    .insn_in     (insn_in),
    .rs_data_in  (rs_data_in),
    .rt_data_in  (rt_data_in),
    .imm_ext_in  (imm_ext_in),
    .valid_out   (valid_out),
    .pc_out      (pc_out),
    .insn_out    (insn_out),
    .rs_data_out (rs_data_out),
    .rt_data_out (rt_data_out),
    .imm_out     (imm_out),
    .alu_b_out   (alu_b_out),
    .alu_op_out  (alu_op_out),
    .shamt_out   (shamt_out),
    .rd_out      (rd_out),
    .b_sel_out   (b_sel_out)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm);
    valid_in   = 1'b1;
    insn_in    = insn;
    pc_in      = pc;
    rs_data_in = rs;
    rt_data_in = rt;
    imm_ext_in = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(32'h28C0000A, 32'h11, 32'h22, 32'h33, 32'h44);
    step(); step();
    total_cnt++;
    if ({valid_out, insn_out, pc_out, rs_data_out, rt_data_out, imm_out, alu_b_out} !== {1'b0, 32'h0, 160'h0})
      $display("FAIL reset_data valid=%0b insn=%h pc=%h rs=%h rt=%h imm=%h alu_b=%h required all zero",
               valid_out, insn_out, pc_out, rs_data_out, rt_data_out, imm_out, alu_b_out);
    else pass_cnt++;
    total_cnt++;
    if ({alu_op_out, shamt_out, rd_out, b_sel_out} !== 16'h0)
      $display("FAIL reset_ctrl alu_op=%0d shamt=%0d rd=%0d b_sel=%0b required 0",
               alu_op_out, shamt_out, rd_out, b_sel_out);
    else pass_cnt++;
    $display("reset: valid=%0b insn=%h rd=%0d", valid_out, insn_out, rd_out);
    reset = 1'b0;
  endtask

  task automatic test_addi();
    drive(32'h28C0000A, 32'h00000005, 32'h00000000, 32'hDEADBEEF, 32'h0000000A);
    step();
    total_cnt++;
    if ({valid_out, alu_b_out, b_sel_out, alu_op_out, rd_out} !== {1'b1, 32'h0000000A, 1'b1, 5'd0, 5'd3})
      $display("FAIL addi valid=%0b alu_b=%h b_sel=%0b alu_op=%0d rd=%0d required 1/0000000a/1/0/3",
               valid_out, alu_b_out, b_sel_out, alu_op_out, rd_out);
    else pass_cnt++;
    total_cnt++;
    if ({pc_out, insn_out, rt_data_out, imm_out} !== {32'h5, 32'h28C0000A, 32'hDEADBEEF, 32'hA})
      $display("FAIL addi_data pc=%h insn=%h rt=%h imm=%h required 00000005/28c0000a/deadbeef/0000000a",
               pc_out, insn_out, rt_data_out, imm_out);
    else pass_cnt++;
    $display("addi: alu_b=%h rd=%0d", alu_b_out, rd_out);
  endtask

  task automatic test_rtype();
    logic [31:0] insns [3];
    logic [4:0]  ops   [3];
    logic [4:0]  shs   [3];
    insns = '{32'h00443000, 32'h00443004, 32'h00443290};
    ops   = '{5'd0, 5'd1, 5'd4};
    shs   = '{5'd0, 5'd0, 5'd5};
    for (int i = 0; i < 3; i++) begin
      drive(insns[i], 32'h20 + i, 32'h9, 32'h5, 32'hFFFF0000);
      step();
      total_cnt++;
      if ({alu_b_out, b_sel_out, alu_op_out, shamt_out, rd_out, rs_data_out} !==
          {32'h5, 1'b0, ops[i], shs[i], 5'd1, 32'h9})
        $display("FAIL rtype%0d alu_b=%h b_sel=%0b alu_op=%0d shamt=%0d rd=%0d rs=%h required 00000005/0/%0d/%0d/1/00000009",
                 i, alu_b_out, b_sel_out, alu_op_out, shamt_out, rd_out, rs_data_out, ops[i], shs[i]);
      else pass_cnt++;
      $display("rtype%0d: insn=%h alu_op=%0d", i, insn_out, alu_op_out);
    end
  endtask

  task automatic test_stall();
    drive(32'h390BFFFE, 32'h40, 32'h1000, 32'hCAFE, 32'hFFFFFFFE);
    step();
    total_cnt++;
    if ({imm_out, alu_b_out, rd_out, b_sel_out, rt_data_out} !== {32'hFFFFFFFE, 32'hFFFFFFFE, 5'd0, 1'b1, 32'hCAFE})
      $display("FAIL sw_capture imm=%h alu_b=%h rd=%0d b_sel=%0b rt=%h required fffffffe/fffffffe/0/1/0000cafe",
               imm_out, alu_b_out, rd_out, b_sel_out, rt_data_out);
    else pass_cnt++;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(32'h00443004 + c, 32'h99, 32'h88, 32'h77, 32'h123);
      valid_in = c[0];
      step();
      total_cnt++;
      if ({valid_out, pc_out, insn_out, imm_out, alu_b_out, rd_out, b_sel_out, alu_op_out} !==
          {1'b1, 32'h40, 32'h390BFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 5'd0, 1'b1, 5'd0})
        $display("FAIL stall_hold%0d valid=%0b pc=%h insn=%h imm=%h alu_b=%h rd=%0d b_sel=%0b required held sw",
                 c, valid_out, pc_out, insn_out, imm_out, alu_b_out, rd_out, b_sel_out);
      else pass_cnt++;
      $display("stall%0d: insn=%h imm=%h", c, insn_out, imm_out);
    end
    stall = 1'b0;
    drive(32'h00443004, 32'h99, 32'h88, 32'h77, 32'h123);
    step();
    total_cnt++;
    if ({valid_out, insn_out, alu_b_out, alu_op_out, b_sel_out, imm_out} !==
        {1'b1, 32'h00443004, 32'h77, 5'd1, 1'b0, 32'h123})
      $display("FAIL stall_release insn=%h alu_b=%h alu_op=%0d b_sel=%0b imm=%h required 00443004/00000077/1/0/00000123",
               insn_out, alu_b_out, alu_op_out, b_sel_out, imm_out);
    else pass_cnt++;
    $display("stall_release: insn=%h", insn_out);
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      drive(32'h41800004, 32'h50, 32'h3, 32'h5, 32'h4);
      step();
      total_cnt++;
      if ({valid_out, rd_out, alu_b_out} !== {1'b1, 5'd6, 32'h4})
        $display("FAIL lw_capture%0d valid=%0b rd=%0d alu_b=%h required 1/6/00000004", k, valid_out, rd_out, alu_b_out);
      else pass_cnt++;
      flush = 1'b1;
      stall = (k == 1);
      step();
      total_cnt++;
      if ({valid_out, insn_out, rd_out, alu_b_out, alu_op_out, b_sel_out, imm_out} !==
          {1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0})
        $display("FAIL flush%0d valid=%0b insn=%h rd=%0d alu_b=%h b_sel=%0b imm=%h required bubble",
                 k, valid_out, insn_out, rd_out, alu_b_out, b_sel_out, imm_out);
      else pass_cnt++;
      $display("flush%0d (stall=%0b): valid=%0b insn=%h", k, stall, valid_out, insn_out);
      flush = 1'b0;
      stall = 1'b0;
    end
    drive(32'h41800004, 32'h50, 32'h3, 32'h5, 32'h4);
    valid_in = 1'b0;
    step();
    total_cnt++;
    if ({valid_out, insn_out, rd_out, alu_b_out, b_sel_out} !== {1'b0, 32'h0, 5'd0, 32'h0, 1'b0})
      $display("FAIL invalid_capture valid=%0b insn=%h rd=%0d alu_b=%h b_sel=%0b required bubble",
               valid_out, insn_out, rd_out, alu_b_out, b_sel_out);
    else pass_cnt++;
    $display("invalid_capture: valid=%0b", valid_out);
  endtask

  task automatic test_dest_override();
    logic [31:0] insns [3];
    logic [4:0]  rds   [3];
    logic [4:0]  ops   [3];
    insns = '{32'h18C00010, 32'hA8000123, 32'h11C00003};
    rds   = '{5'd31, 5'd30, 5'd0};
    ops   = '{5'd0, 5'd0, 5'd1};
    for (int i = 0; i < 3; i++) begin
      drive(insns[i], 32'h60, 32'h1, 32'h2, 32'h3);
      step();
      total_cnt++;
      if ({rd_out, b_sel_out, alu_op_out, alu_b_out} !== {rds[i], 1'b0, ops[i], 32'h2})
        $display("FAIL dest%0d rd=%0d b_sel=%0b alu_op=%0d alu_b=%h required %0d/0/%0d/00000002",
                 i, rd_out, b_sel_out, alu_op_out, alu_b_out, rds[i], ops[i]);
      else pass_cnt++;
      $display("dest%0d: insn=%h rd=%0d", i, insn_out, rd_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(32'h41800004, 32'h70, 32'h3, 32'h5, 32'h4);
    step();
    stall = 1'b1;
    reset = 1'b1;
    step();
    total_cnt++;
    if ({valid_out, insn_out, pc_out, imm_out, alu_b_out, rd_out, b_sel_out} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0})
      $display("FAIL reset_stall valid=%0b insn=%h pc=%h imm=%h rd=%0d b_sel=%0b required reset values",
               valid_out, insn_out, pc_out, imm_out, rd_out, b_sel_out);
    else pass_cnt++;
    reset = 1'b0;
    stall = 1'b0;
    drive(32'h28C0000A, 32'h71, 32'h0, 32'h1, 32'hA);
    step();
    total_cnt++;
    if ({valid_out, pc_out, rd_out, b_sel_out, alu_b_out} !== {1'b1, 32'h71, 5'd3, 1'b1, 32'hA})
      $display("FAIL resume valid=%0b pc=%h rd=%0d b_sel=%0b alu_b=%h required 1/00000071/3/1/0000000a",
               valid_out, pc_out, rd_out, b_sel_out, alu_b_out);
    else pass_cnt++;
    $display("reset_stall: resumed pc=%h", pc_out);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_stall();
    test_flush();
    test_dest_override();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_execute_latch.md
Name: decode_execute_latch

Overview:
- Pipeline register between decode and execute in the 5-stage processor.
- Captures from decode:
  - PC
  - instruction word
  - register-file read data
  - 32-bit sign-extended immediate, produced by the 17-to-32 sign extender in decode
- Pre-decodes execute-stage control: ALU opcode, shamt, operand-B select, destination register.
- Presents all of the above to the ALU and bypass logic one cycle later.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register index width.
- NOP_INSN, 32'h00000000, instruction word injected on flush/reset.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all outputs this cycle.
- flush  in  1  replace the captured instruction with a bubble.
- valid_in  in  1  decode stage holds a real instruction.
- pc_in  in  32  PC+1 of the decode instruction.
- insn_in  in  32  decode instruction word.
- rs_data_in  in  32  regfile port A data.
- rt_data_in  in  32  regfile port B data (rd for I-type stores/branches).
- imm_ext_in  in  32  sign-extended immediate from decode.
- valid_out  out  1  execute holds a real instruction.
- pc_out  out  32  latched PC.
- insn_out  out  32  latched instruction.
- rs_data_out  out  32  latched operand A.
- rt_data_out  out  32  latched register B data (store data / branch compare).
- imm_out  out  32  latched immediate.
- alu_b_out  out  32  ALU operand B: imm_ext_in if operand-B select is 1, else rt_data_in.
- alu_op_out  out  5  execute ALU opcode.
- shamt_out  out  5  shift amount, insn[11:7].
- rd_out  out  5  destination register index, insn[26:22]; 0 for stores and branches.
- b_sel_out  out  1  1 = immediate operand.

Behaviour:
- All state updates on the rising clock edge. Latency is 1 cycle from input to output.
- Reset (synchronous, active-high):
  - valid_out=0, insn_out=NOP_INSN.
  - All data outputs = 0; alu_op_out, shamt_out, rd_out = 0; b_sel_out=0.
- Update rule, in priority order:
  - reset: reset values.
  - flush: bubble.
  - stall: hold all outputs.
  - else: capture.
- flush with stall in the same cycle: flush wins, so a bubble is inserted.
- Bubble:
  - valid_out=0, insn_out=NOP_INSN.
  - rd_out=0, alu_op_out=0, b_sel_out=0.
  - Data outputs are cleared to 0.
- Capture with valid_in=0: same as bubble.
- Opcode decode, op = insn_in[31:27]:
  - 00000 R-type: alu_op=insn[6:2], b_sel=0, rd=insn[26:22].
  - 00101 addi, 01000 lw: alu_op=00000, b_sel=1, rd=insn[26:22].
  - 00111 sw: alu_op=00000, b_sel=1, rd=0.
  - 00010 bne, 00110 blt: alu_op=00001 (subtract), b_sel=0, rd=0.
  - 00011 jal: alu_op=0, b_sel=0, rd=31.
  - 10101 setx: alu_op=0, b_sel=0, rd=30.
  - All others (j, jr, bex, unused): alu_op=0, b_sel=0, rd=0.
- alu_b_out is computed from the same-cycle inputs, so it always matches the latched b_sel_out.
- imm_ext_in is latched unmodified. No re-extension; width is DATA_W.
- Reset asserted while stall is held: reset wins; stall is released on the next cycle.
- No internal counters. Stall may be held for any number of cycles with no output change.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_J, OP_JAL, OP_JR, OP_BEX, OP_SETX.
  - ALU op constants: ALU_ADD=00000, ALU_SUB=00001.
  - register constants: REG_RA=31, REG_STATUS=30.
  - NOP_INSN.
- One sub-module, execute_control_decode (combinational):
  - input: opcode and instruction fields.
  - outputs: alu_op, b_sel, rd.
  - its outputs feed the latch registers.

Test Plan:
- Reset, then capture of addi:
  - stimulus: reset held for 2 cycles, release; then insn=0x28C0000A (addi r3,r0,10), imm_ext_in=0x0000000A, rt_data_in=0xDEADBEEF, valid_in=1.
  - response: after one edge, valid_out=1, alu_b_out=0x0000000A, b_sel_out=1, alu_op_out=0, rd_out=3.
- R-type capture:
  - stimulus: insn = add r1,r2,r3 (alu_op 00000), then sub (insn[6:2]=00001); rt_data_in=0x5.
  - response: alu_b_out=0x5, b_sel_out=0, alu_op_out follows insn[6:2].
- Stall:
  - stimulus: capture an sw with imm_ext_in=0xFFFFFFFE; assert stall for 3 cycles while changing all inputs.
  - response: outputs unchanged for all 3 cycles, imm_out=0xFFFFFFFE, rd_out=0; new inputs are captured on the first edge after stall drops.
- Flush, and flush with stall:
  - stimulus: flush=1 alone; separately flush=1 with stall=1.
  - response: in both cases, after the edge, valid_out=0, insn_out=0, rd_out=0, alu_b_out=0.
- jal and setx destination override:
  - stimulus: insn opcode 00011, then opcode 10101.
  - response: rd_out=31, then rd_out=30; b_sel_out=0 for both.
- Reset mid-stall:
  - stimulus: valid lw latched, stall=1, reset=1 for one cycle.
  - response: all outputs at reset values on the next edge; normal capture resumes once reset and stall are low.
